// File: rtl/alu_operand_entry.sv
// alu_operand_entry
//   Operand/opcode entry front end for a board-level ALU demo. Two raw push
//   buttons are synchronized and debounced. Each press of btn_next latches the
//   switch value into the next slot: A, then B, then the opcode. The optional
//   btn_back steps back one stage without changing any stored value.
//
//   Build option: define ALU_ENTRY_BACK_EN to compile in the btn_back path.
//   When it is undefined, btn_back is ignored and has no synchronizer and no
//   debouncer.
//
// Parameters
//   DB_CYCLES  debounce stable time in clk cycles (legal range 2 .. 2^24-1)
//
// Ports
//   clk       system clock; all state updates on its rising edge
//   rst       asynchronous reset, active low
//   sw        raw switches; operand or opcode value to load
//   btn_next  raw push button, active high; advances the entry stage
//   btn_back  raw push button, active high; returns one entry stage
//   a, b      registered operands
//   op        registered opcode (taken from sw[3:0])
//   stage     current entry stage: 0=A, 1=B, 2=OP, 3=DONE
//   valid     one-cycle pulse when a complete new operand set is present
//
// A clean raw press that first meets a clock edge at edge N causes the FSM
// to update at edge N+DB_CYCLES+2. Counting from the clock edge at which the
// raw input changed, that is DB_CYCLES+3 cycles.

module alu_operand_entry #(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       btn_next,
    input  logic       btn_back,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [3:0] op,
    output logic [1:0] stage,
    output logic       valid
);

    localparam int unsigned CntW = 24;
    localparam logic [CntW-1:0] DbMax = CntW'(DB_CYCLES - 1);

`ifdef ALU_ENTRY_BACK_EN
    localparam int unsigned NumBtn = 2;
`else
    localparam int unsigned NumBtn = 1;
`endif

    typedef enum logic [1:0] {
        StA    = 2'd0,
        StB    = 2'd1,
        StOp   = 2'd2,
        StDone = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Button inputs (bit 0 = next, bit 1 = back when compiled in)
    // ------------------------------------------------------------------
    logic [NumBtn-1:0] btn_raw;

`ifdef ALU_ENTRY_BACK_EN
    assign btn_raw = {btn_back, btn_next};
`else
    logic unused_btn_back;
    assign btn_raw         = btn_next;
    assign unused_btn_back = btn_back;
`endif

    // ------------------------------------------------------------------
    // Synchronizers and debouncers
    // ------------------------------------------------------------------
    logic [NumBtn-1:0] sync1_q;
    logic [NumBtn-1:0] sync2_q;
    logic [NumBtn-1:0] deb_q;
    logic [NumBtn-1:0] deb_d;
    logic [NumBtn-1:0] deb_prev_q;
    logic [NumBtn-1:0] press;
    logic [CntW-1:0]   cnt_q [NumBtn];
    logic [CntW-1:0]   cnt_d [NumBtn];

    // The counter only runs while a level change is pending, so any return
    // of the synchronized level to the debounced level restarts the wait.
    always_comb begin
        for (int i = 0; i < int'(NumBtn); i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DbMax) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < int'(NumBtn); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < int'(NumBtn); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Rising edge of the debounced level only; releases give no event.
    assign press = deb_q & ~deb_prev_q;

    logic ev_next;
    logic ev_back;

`ifdef ALU_ENTRY_BACK_EN
    // Coincident next and back cancel each other.
    assign ev_next = press[0] & ~press[1];
    assign ev_back = press[1] & ~press[0];
`else
    assign ev_next = press[0];
    assign ev_back = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Entry FSM: state register
    // ------------------------------------------------------------------
    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StA;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StA: begin
                if (ev_next) state_d = StB;
            end
            StB: begin
                if (ev_next)      state_d = StOp;
                else if (ev_back) state_d = StA;
            end
            StOp: begin
                if (ev_next)      state_d = StDone;
                else if (ev_back) state_d = StB;
            end
            StDone: begin
                if (ev_next)      state_d = StA;
                else if (ev_back) state_d = StOp;
            end
            default: state_d = StA;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand registers and valid pulse
    // ------------------------------------------------------------------
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [3:0] op_q;
    logic       valid_q;

    // sw is deliberately not synchronized: it is only sampled in the event
    // cycle, long after the switches have settled behind the debounce delay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            if (ev_next) begin
                unique case (state_q)
                    StA:     a_q  <= sw;
                    StB:     b_q  <= sw;
                    StOp:    op_q <= sw[3:0];
                    default: ;
                endcase
            end
            valid_q <= (state_d == StDone) && (state_q != StDone);
        end
    end

    // ------------------------------------------------------------------
    // Entry FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        stage = state_q;
        valid = valid_q;
        a     = a_q;
        b     = b_q;
        op    = op_q;
    end

endmodule

// File: tb/tb_alu_operand_entry.sv
module tb_alu_operand_entry;

    localparam int unsigned DB  = 4;
    localparam int unsigned LAT = DB + 3;

`ifdef ALU_ENTRY_BACK_EN
    localparam bit BackEn = 1'b1;
`else
    localparam bit BackEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw;
    logic       btn_next;
    logic       btn_back;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [1:0] stage;
    logic       valid;

    alu_operand_entry #(.DB_CYCLES(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .btn_next (btn_next),
        .btn_back (btn_back),
        .a        (a),
        .b        (b),
        .op       (op),
        .stage    (stage),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: stage number and stored values, updated per event.
    int         m_stage;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [3:0] m_op;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic exp_valid);
        check({tag, ".stage"}, 32'(stage), 32'(m_stage));
        check({tag, ".a"}, 32'(a), 32'(m_a));
        check({tag, ".b"}, 32'(b), 32'(m_b));
        check({tag, ".op"}, 32'(op), 32'(m_op));
        check({tag, ".valid"}, 32'(valid), 32'(exp_valid));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_stage = 0;
        m_a     = '0;
        m_b     = '0;
        m_op    = '0;
    endtask

    // Apply one event to the model; returns the expected valid value.
    task automatic model_event(input bit nxt, input bit bck, input logic [7:0] swv,
                               output logic vld);
        bit ev_n;
        bit ev_b;
        ev_n = nxt && !(bck && BackEn);
        ev_b = bck && BackEn && !nxt;
        vld  = 1'b0;
        if (ev_n) begin
            if (m_stage == 0) m_a = swv;
            else if (m_stage == 1) m_b = swv;
            else if (m_stage == 2) m_op = swv[3:0];
            m_stage = (m_stage + 1) % 4;
            vld = (m_stage == 3);
        end else if (ev_b) begin
            if (m_stage > 0) m_stage = m_stage - 1;
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_all(tag, 1'b0);
        end
    endtask

    // Press buttons for 'hold' cycles; the effect must land exactly LAT cycles
    // after the raw edge, once, and sw changes afterwards must not matter.
    task automatic do_press(input string tag, input bit nxt, input bit bck,
                            input logic [7:0] swv, input int hold);
        logic vld;
        sw       = swv;
        btn_next = nxt;
        btn_back = bck;
        for (int c = 1; c < int'(LAT); c++) begin
            tick();
            check_all({tag, ".pre"}, 1'b0);
        end
        tick();
        model_event(nxt, bck, swv, vld);
        check_all({tag, ".evt"}, vld);
        for (int c = int'(LAT) + 1; c <= hold; c++) begin
            sw = 8'($urandom);
            tick();
            check_all({tag, ".hold"}, 1'b0);
        end
        btn_next = 1'b0;
        btn_back = 1'b0;
        idle({tag, ".rel"}, int'(DB) + 4);
    endtask

    task automatic glitch(input string tag, input int w, input int gap);
        btn_next = 1'b1;
        for (int i = 0; i < w; i++) begin
            tick();
            check_all(tag, 1'b0);
        end
        btn_next = 1'b0;
        for (int i = 0; i < gap; i++) begin
            tick();
            check_all(tag, 1'b0);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all("rst.async", 1'b0);
        tick();
        tick();
        check_all("rst.held", 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic vld;
        int   kind;
        rst      = 1'b0;
        sw       = '0;
        btn_next = 1'b0;
        btn_back = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();
        idle("idle0", 3);

        // Single held press loads A and moves to B, exactly once.
        do_press("p3c", 1'b1, 1'b0, 8'h3C, 20);

        // Reset in the middle of a debounce while in B, button still held.
        sw       = 8'h55;
        btn_next = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_all("mid.pre", 1'b0);
        end
        rst = 1'b0;
        #1;
        model_reset();
        check_all("mid.rst", 1'b0);
        tick();
        tick();
        check_all("mid.rsth", 1'b0);
        rst = 1'b1;
        for (int c = 1; c < int'(LAT); c++) begin
            tick();
            check_all("mid.wait", 1'b0);
        end
        tick();
        model_event(1'b1, 1'b0, 8'h55, vld);
        check_all("mid.evt", vld);
        tick();
        check_all("mid.after", 1'b0);
        btn_next = 1'b0;
        idle("mid.rel", int'(DB) + 4);

        // Full entry sequence.
        apply_reset();
        idle("idle1", 2);
        do_press("s12", 1'b1, 1'b0, 8'h12, 10);
        do_press("s34", 1'b1, 1'b0, 8'h34, 10);
        do_press("s0a", 1'b1, 1'b0, 8'h0A, 10);
        check(("seq.a"), 32'(a), 32'h12);
        check(("seq.b"), 32'(b), 32'h34);
        check(("seq.op"), 32'(op), 32'hA);
        check(("seq.stage"), 32'(stage), 32'd3);

        // Short glitches must never register.
        for (int i = 0; i < 8; i++) glitch("gl2", 2, 2);
        idle("gl.idle", int'(DB) + 4);

        // From DONE, next returns to A and keeps the values.
        do_press("done", 1'b1, 1'b0, 8'hFF, 10);
        check(("done.a"), 32'(a), 32'h12);
        check(("done.op"), 32'(op), 32'hA);

        // Back handling (no effect when the back path is not built).
        do_press("toB", 1'b1, 1'b0, 8'h21, 10);
        do_press("toOp", 1'b1, 1'b0, 8'h43, 10);
        do_press("back", 1'b0, 1'b1, 8'h99, 10);
        do_press("both", 1'b1, 1'b1, 8'h77, 10);

        // Randomized mix of presses and glitches.
        for (int it = 0; it < 16; it++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 6) begin
                do_press("rnd.n", 1'b1, 1'b0, 8'($urandom), int'(LAT) + 1 + int'($urandom_range(0, 5)));
            end else if (kind < 8) begin
                do_press("rnd.b", 1'b0, 1'b1, 8'($urandom), int'(LAT) + 1 + int'($urandom_range(0, 5)));
            end else begin
                glitch("rnd.g", int'($urandom_range(1, DB - 1)), int'($urandom_range(1, 4)));
                idle("rnd.gi", int'(DB) + 4);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
